// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode field values, link register index,
// fetch FSM encoding and word size.
package mips_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned WORD_BYTES = 4;

  // instr[31:26] values consumed by the control decoder
  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;

  localparam logic [4:0] LINK_REG = 5'd31;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_ERR  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/mips_npc_calc.sv
// Next-PC calculation from resolved branch/jump outcomes (combinational).
//  in : ex_valid, ex_branch, ex_zero, ex_jump, ex_jal, ex_pc_plus4, ex_imm, ex_target
//  out: redirect_c (take the new PC), npc_c (redirect target)
module mips_npc_calc
  import mips_pkg::*;
(
  input  logic            ex_valid,
  input  logic            ex_branch,
  input  logic            ex_zero,
  input  logic            ex_jump,
  input  logic            ex_jal,
  input  logic [XLEN-1:0] ex_pc_plus4,
  input  logic [15:0]     ex_imm,
  input  logic [25:0]     ex_target,
  output logic            redirect_c,
  output logic [XLEN-1:0] npc_c
);

  logic            take_jump;
  logic            take_branch;
  logic [XLEN-1:0] br_off;

  // jal is a jump that also links
  assign take_jump   = ex_jump | ex_jal;
  assign take_branch = ex_branch & ex_zero;
  assign redirect_c  = ex_valid & (take_jump | take_branch);

  assign br_off = {{14{ex_imm[15]}}, ex_imm, 2'b00};

  // Jump wins over branch; branch add wraps at 32 bits
  assign npc_c = take_jump ? {ex_pc_plus4[31:28], ex_target, 2'b00}
                           : ex_pc_plus4 + br_off;

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake,
// holds the word for decode and redirects on resolved branch/jump/jal.
//  imem_req/imem_addr/imem_ack/imem_rdata : instruction memory handshake
//  if_valid/if_ready/if_instr/if_pc/if_pc_plus4 : handoff to decode
//  ex_*      : resolution of the executing control-flow instruction
//  link_we/link_addr/link_data : $ra write for jal
//  fetch_err : sticky memory timeout flag
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  input  logic        ex_valid,
  input  logic        ex_branch,
  input  logic        ex_zero,
  input  logic        ex_jump,
  input  logic        ex_jal,
  input  logic [31:0] ex_pc_plus4,
  input  logic [15:0] ex_imm,
  input  logic [25:0] ex_target,
  output logic        link_we,
  output logic [4:0]  link_addr,
  output logic [31:0] link_data,
  output logic        fetch_err
);

  localparam int unsigned WCW = $clog2(WAIT_LIMIT + 1);

  fetch_state_e    state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [WCW-1:0]  wait_q, wait_d;
  logic            drop_q, drop_d;
  logic            req_d, valid_d, err_d;
  logic [31:0]     addr_d, instr_d, ifpc_d, ifpc4_d;
  logic            redirect_c;
  logic [31:0]     npc_c;

  mips_npc_calc u_npc (
    .ex_valid    (ex_valid),
    .ex_branch   (ex_branch),
    .ex_zero     (ex_zero),
    .ex_jump     (ex_jump),
    .ex_jal      (ex_jal),
    .ex_pc_plus4 (ex_pc_plus4),
    .ex_imm      (ex_imm),
    .ex_target   (ex_target),
    .redirect_c  (redirect_c),
    .npc_c       (npc_c)
  );

  assign link_addr = LINK_REG;

  // Next-state and next-output logic. S_REQ has an issue cycle (req low,
  // address loaded from pc) followed by the wait cycles with req high.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wait_d  = wait_q;
    drop_d  = drop_q;
    req_d   = imem_req;
    addr_d  = imem_addr;
    valid_d = 1'b0;
    instr_d = if_instr;
    ifpc_d  = if_pc;
    ifpc4_d = if_pc_plus4;
    err_d   = fetch_err;

    unique case (state_q)
      S_BOOT: state_d = S_REQ;

      S_REQ: begin
        if (!imem_req) begin
          req_d  = 1'b1;
          addr_d = pc_q;
          wait_d = '0;
          // Request already launched at the old pc: mark it stale
          if (redirect_c) begin
            drop_d = 1'b1;
            pc_d   = npc_c;
          end
        end else if (imem_ack) begin
          req_d  = 1'b0;
          wait_d = '0;
          if (drop_q || redirect_c) begin
            drop_d = 1'b0;
            if (redirect_c) pc_d = npc_c;
          end else begin
            instr_d = imem_rdata;
            ifpc_d  = pc_q;
            ifpc4_d = pc_q + 32'(WORD_BYTES);
            pc_d    = pc_q + 32'(WORD_BYTES);
            valid_d = 1'b1;
            state_d = S_HOLD;
          end
        end else if (wait_q == WCW'(WAIT_LIMIT - 1)) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + WCW'(1);
          // Address must not move mid-request; retarget after the ack
          if (redirect_c) begin
            drop_d = 1'b1;
            pc_d   = npc_c;
          end
        end
      end

      S_HOLD: begin
        valid_d = 1'b1;
        if (redirect_c) begin
          pc_d    = npc_c;
          valid_d = 1'b0;
          state_d = S_REQ;
        end else if (if_ready) begin
          valid_d = 1'b0;
          state_d = S_REQ;
        end
      end

      S_ERR: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
        err_d   = 1'b1;
      end

      default: state_d = S_BOOT;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_BOOT;
      pc_q        <= RESET_PC;
      wait_q      <= '0;
      drop_q      <= 1'b0;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      if_valid    <= 1'b0;
      if_instr    <= '0;
      if_pc       <= '0;
      if_pc_plus4 <= '0;
      fetch_err   <= 1'b0;
      link_we     <= 1'b0;
      link_data   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      wait_q      <= wait_d;
      drop_q      <= drop_d;
      imem_req    <= req_d;
      imem_addr   <= addr_d;
      if_valid    <= valid_d;
      if_instr    <= instr_d;
      if_pc       <= ifpc_d;
      if_pc_plus4 <= ifpc4_d;
      fetch_err   <= err_d;
      // Link write is independent of fetch state
      link_we     <= ex_valid & ex_jal;
      if (ex_valid && ex_jal) link_data <= ex_pc_plus4;
    end
  end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit.
module tb_mips_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        ex_valid;
  logic        ex_branch;
  logic        ex_zero;
  logic        ex_jump;
  logic        ex_jal;
  logic [31:0] ex_pc_plus4;
  logic [15:0] ex_imm;
  logic [25:0] ex_target;
  logic        link_we;
  logic [4:0]  link_addr;
  logic [31:0] link_data;
  logic        fetch_err;

  int total = 0;
  int bad   = 0;

  mips_fetch_unit #(.RESET_PC(32'h0000_0000), .WAIT_LIMIT(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_pc_plus4 (if_pc_plus4),
    .ex_valid    (ex_valid),
    .ex_branch   (ex_branch),
    .ex_zero     (ex_zero),
    .ex_jump     (ex_jump),
    .ex_jal      (ex_jal),
    .ex_pc_plus4 (ex_pc_plus4),
    .ex_imm      (ex_imm),
    .ex_target   (ex_target),
    .link_we     (link_we),
    .link_addr   (link_addr),
    .link_data   (link_data),
    .fetch_err   (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction word returned for a given address
  function automatic logic [31:0] mk(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid = 0; ex_branch = 0; ex_zero = 0; ex_jump = 0; ex_jal = 0;
    ex_pc_plus4 = '0; ex_imm = '0; ex_target = '0;
  endtask

  task automatic test_reset();
    rst_n = 0; imem_ack = 0; imem_rdata = '0; if_ready = 0;
    clear_ex();
    tick(); tick();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", if_valid); end
    total++; if (if_instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=0", if_instr); end
    total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", fetch_err); end
    total++; if (link_we !== 1'b0 || link_data !== 32'h0) begin bad++; $display("FAIL rst_link got=%b/%h exp=0/0", link_we, link_data); end
    total++; if (link_addr !== 5'd31) begin bad++; $display("FAIL link_addr got=%0d exp=31", link_addr); end
    rst_n = 1;
    tick();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL boot_req got=%b exp=0", imem_req); end
    tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL first_req got=%b/%h exp=1/0", imem_req, imem_addr); end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      a = 32'(i * 4);
      total++; if (imem_req !== 1'b1 || imem_addr !== a) begin bad++; $display("FAIL seq_req%0d got=%b/%h exp=1/%h", i, imem_req, imem_addr, a); end
      imem_ack = 1; imem_rdata = mk(a); if_ready = 1;
      tick();
      imem_ack = 0;
      total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL seq_valid%0d got=%b exp=1", i, if_valid); end
      total++; if (if_instr !== mk(a) || if_pc !== a) begin bad++; $display("FAIL seq_data%0d got=%h/%h exp=%h/%h", i, if_instr, if_pc, mk(a), a); end
      total++; if (if_pc_plus4 !== a + 32'd4) begin bad++; $display("FAIL seq_pc4_%0d got=%h exp=%h", i, if_pc_plus4, a + 32'd4); end
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL seq_reqlow%0d got=%b exp=0", i, imem_req); end
      tick();
      total++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin bad++; $display("FAIL seq_gap%0d got=%b/%b exp=0/0", i, if_valid, imem_req); end
      tick();
    end
  endtask

  task automatic test_stall();
    if_ready = 0; imem_ack = 1; imem_rdata = mk(32'h10);
    tick();
    imem_ack = 0;
    for (int k = 0; k < 5; k++) begin
      total++; if (if_valid !== 1'b1 || if_pc !== 32'h10 || if_instr !== mk(32'h10)) begin bad++; $display("FAIL stall_hold%0d got=%b/%h/%h exp=1/10/%h", k, if_valid, if_pc, if_instr, mk(32'h10)); end
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_req%0d got=%b exp=0", k, imem_req); end
      tick();
    end
    if_ready = 1;
    tick();
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL stall_release got=%b exp=0", if_valid); end
    tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin bad++; $display("FAIL stall_next got=%b/%h exp=1/14", imem_req, imem_addr); end
  endtask

  task automatic test_branch();
    if_ready = 0; imem_ack = 1; imem_rdata = mk(32'h14);
    tick();
    imem_ack = 0;
    ex_valid = 1; ex_branch = 1; ex_zero = 0; ex_pc_plus4 = 32'h10; ex_imm = 16'hFFFE;
    tick();
    clear_ex();
    total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL br_nottaken_valid got=%b exp=1", if_valid); end
    total++; if (link_we !== 1'b0) begin bad++; $display("FAIL br_link got=%b exp=0", link_we); end
    if_ready = 1;
    tick(); tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h18) begin bad++; $display("FAIL br_nottaken_addr got=%b/%h exp=1/18", imem_req, imem_addr); end
    if_ready = 0; imem_ack = 1; imem_rdata = mk(32'h18);
    tick();
    imem_ack = 0;
    ex_valid = 1; ex_branch = 1; ex_zero = 1; ex_pc_plus4 = 32'h10; ex_imm = 16'hFFFE;
    tick();
    clear_ex();
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL br_squash got=%b exp=0", if_valid); end
    tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h08) begin bad++; $display("FAIL br_taken_addr got=%b/%h exp=1/08", imem_req, imem_addr); end
  endtask

  task automatic test_jal();
    if_ready = 0; imem_ack = 1; imem_rdata = mk(32'h08);
    tick();
    imem_ack = 0;
    ex_valid = 1; ex_jump = 1; ex_jal = 1; ex_pc_plus4 = 32'h9000_0004; ex_target = 26'h0000100;
    tick();
    clear_ex();
    total++; if (link_we !== 1'b1 || link_data !== 32'h9000_0004) begin bad++; $display("FAIL jal_link got=%b/%h exp=1/90000004", link_we, link_data); end
    total++; if (link_addr !== 5'd31) begin bad++; $display("FAIL jal_laddr got=%0d exp=31", link_addr); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL jal_squash got=%b exp=0", if_valid); end
    tick();
    total++; if (link_we !== 1'b0) begin bad++; $display("FAIL jal_pulse got=%b exp=0", link_we); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h9000_0400) begin bad++; $display("FAIL jal_addr got=%b/%h exp=1/90000400", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_wait();
    tick();
    ex_valid = 1; ex_jump = 1; ex_pc_plus4 = 32'h0; ex_target = 26'h40;
    tick();
    clear_ex();
    for (int k = 0; k < 3; k++) begin
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h9000_0400 || if_valid !== 1'b0) begin bad++; $display("FAIL rw_hold%0d got=%b/%h/%b exp=1/90000400/0", k, imem_req, imem_addr, if_valid); end
      if (k < 2) tick();
    end
    imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 0;
    total++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin bad++; $display("FAIL rw_drop got=%b/%b exp=0/0", if_valid, imem_req); end
    tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || if_valid !== 1'b0) begin bad++; $display("FAIL rw_newreq got=%b/%h/%b exp=1/100/0", imem_req, imem_addr, if_valid); end
    imem_ack = 1; imem_rdata = mk(32'h100); if_ready = 1;
    tick();
    imem_ack = 0;
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== mk(32'h100)) begin bad++; $display("FAIL rw_fetch got=%b/%h/%h exp=1/100/%h", if_valid, if_pc, if_instr, mk(32'h100)); end
  endtask

  task automatic test_timeout();
    tick(); tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin bad++; $display("FAIL to_req got=%b/%h exp=1/104", imem_req, imem_addr); end
    for (int k = 0; k < 15; k++) begin
      tick();
      total++; if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin bad++; $display("FAIL to_wait%0d got=%b/%b exp=1/0", k, imem_req, fetch_err); end
    end
    tick();
    total++; if (fetch_err !== 1'b1 || imem_req !== 1'b0) begin bad++; $display("FAIL to_err got=%b/%b exp=1/0", fetch_err, imem_req); end
    ex_valid = 1; ex_jump = 1; ex_jal = 1; ex_pc_plus4 = 32'h2000; ex_target = 26'h10;
    tick();
    clear_ex();
    total++; if (link_we !== 1'b1 || link_data !== 32'h2000) begin bad++; $display("FAIL to_link got=%b/%h exp=1/2000", link_we, link_data); end
    tick(); tick();
    total++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || if_valid !== 1'b0) begin bad++; $display("FAIL to_sticky got=%b/%b/%b exp=1/0/0", fetch_err, imem_req, if_valid); end
  endtask

  task automatic test_reset_mid();
    rst_n = 0;
    #1;
    total++; if (fetch_err !== 1'b0 || link_data !== 32'h0) begin bad++; $display("FAIL rm_clr got=%b/%h exp=0/0", fetch_err, link_data); end
    tick();
    rst_n = 1;
    tick(); tick();
    imem_ack = 1; imem_rdata = mk(32'h0); if_ready = 1;
    tick();
    imem_ack = 0;
    tick(); tick(); tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h4 || if_instr !== mk(32'h0)) begin bad++; $display("FAIL rm_pre got=%b/%h/%h exp=1/4/%h", imem_req, imem_addr, if_instr, mk(32'h0)); end
    rst_n = 0;
    #1;
    total++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || if_valid !== 1'b0) begin bad++; $display("FAIL rm_fetch got=%b/%h/%b exp=0/0/0", imem_req, imem_addr, if_valid); end
    total++; if (if_instr !== 32'h0 || if_pc !== 32'h0 || if_pc_plus4 !== 32'h0) begin bad++; $display("FAIL rm_hold got=%h/%h/%h exp=0/0/0", if_instr, if_pc, if_pc_plus4); end
    total++; if (link_we !== 1'b0 || fetch_err !== 1'b0) begin bad++; $display("FAIL rm_misc got=%b/%b exp=0/0", link_we, fetch_err); end
    tick();
    rst_n = 1;
    tick(); tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL rm_restart got=%b/%h exp=1/0", imem_req, imem_addr); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_jal();
    test_redirect_wait();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
